// File: rtl/iic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iic_pkg : FSM states, byte-step codes and step sequencing helpers    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package iic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      STEP_DEV_W   = 3'd0,
      STEP_REG_HI  = 3'd1,
      STEP_REG_LO  = 3'd2,
      STEP_WR_DATA = 3'd3,
      STEP_DEV_R   = 3'd4,
      STEP_RD_DATA = 3'd5
   } step_t;

   localparam logic C_DIR_TX = 1'b0;
   localparam logic C_DIR_RX = 1'b1;

   function automatic step_t next_step(input step_t s, input logic rnw, input logic two_byte);
      step_t n;
      n = s;
      case (s)
         STEP_DEV_W:  n = two_byte ? STEP_REG_HI : STEP_REG_LO;
         STEP_REG_HI: n = STEP_REG_LO;
         STEP_REG_LO: n = rnw ? STEP_DEV_R : STEP_WR_DATA;
         STEP_DEV_R:  n = STEP_RD_DATA;
         default:     n = s;
      endcase
      return n;
   endfunction

   function automatic logic is_last_step(input step_t s);
      return (s == STEP_WR_DATA) || (s == STEP_RD_DATA);
   endfunction

endpackage
`default_nettype wire

// File: rtl/iic_reg_access_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iic_reg_access_if : host request/response and byte-controller ports  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface iic_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_rnw;
   logic        req_dev_sel;
   logic [6:0]  req_dev;
   logic [15:0] req_reg;
   logic [7:0]  req_wdata;
   logic        rsp_done;
   logic        rsp_err;
   logic [7:0]  rsp_rdata;

   modport master (
      output req_valid, req_rnw, req_dev_sel, req_dev, req_reg, req_wdata,
      input  req_ready, rsp_done, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_rnw, req_dev_sel, req_dev, req_reg, req_wdata,
      output req_ready, rsp_done, rsp_err, rsp_rdata
   );
endinterface

interface iic_ctl_if;
   logic [7:0] ctl_data_tx;
   logic [7:0] ctl_data_rx;
   logic       ctl_start;
   logic       ctl_stop;
   logic       ctl_dir;
   logic       ctl_do;
   logic       ctl_ready;
   logic       ctl_error;

   modport master (
      output ctl_data_tx, ctl_start, ctl_stop, ctl_dir, ctl_do,
      input  ctl_data_rx, ctl_ready, ctl_error
   );

   modport slave (
      input  ctl_data_tx, ctl_start, ctl_stop, ctl_dir, ctl_do,
      output ctl_data_rx, ctl_ready, ctl_error
   );
endinterface
`default_nettype wire

// File: rtl/iic_reg_access.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iic_reg_access : register read/write to I2C byte-command sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iic_reg_access
   import iic_pkg::*;
#(
   parameter int         REG_ADDR_BYTES = 1,
   parameter logic [6:0] DEV_ADDR       = 7'h50
) (
   input  logic      clk,
   input  logic      rst,
   iic_req_if.slave  host,
   iic_ctl_if.master ctl
);

   generate
      if ((REG_ADDR_BYTES != 1) && (REG_ADDR_BYTES != 2)) begin : g_bad_reg_addr_bytes
         $error("iic_reg_access: REG_ADDR_BYTES must be 1 or 2");
      end
   endgenerate

   localparam logic C_TWO_BYTE = (REG_ADDR_BYTES == 2);

   state_t      r_state;
   step_t       r_step;
   logic        r_skip;
   logic        r_rnw;
   logic [6:0]  r_dev;
   logic [15:0] r_reg;
   logic [7:0]  r_wdata;
   logic        r_req_ready;
   logic        r_rsp_done;
   logic        r_rsp_err;
   logic [7:0]  r_rsp_rdata;
   logic [7:0]  r_data_tx;
   logic        r_start;
   logic        r_stop;
   logic        r_dir;
   logic        r_do;

   logic [7:0]  w_tx_byte;
   logic        w_start;
   logic        w_stop;
   logic        w_dir;

   always_comb begin
      w_tx_byte = 8'h00;
      w_start   = 1'b0;
      w_stop    = 1'b0;
      w_dir     = C_DIR_TX;
      case (r_step)
         STEP_DEV_W: begin
            w_tx_byte = {r_dev, 1'b0};
            w_start   = 1'b1;
         end
         STEP_REG_HI:  w_tx_byte = r_reg[15:8];
         STEP_REG_LO:  w_tx_byte = r_reg[7:0];
         STEP_WR_DATA: begin
            w_tx_byte = r_wdata;
            w_stop    = 1'b1;
         end
         STEP_DEV_R: begin
            w_tx_byte = {r_dev, 1'b1};
            w_start   = 1'b1;
         end
         STEP_RD_DATA: begin
            w_stop = 1'b1;
            w_dir  = C_DIR_RX;
         end
         default: w_tx_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_step      <= STEP_DEV_W;
         r_skip      <= 1'b0;
         r_rnw       <= 1'b0;
         r_dev       <= 7'h00;
         r_reg       <= 16'h0000;
         r_wdata     <= 8'h00;
         r_req_ready <= 1'b1;
         r_rsp_done  <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= 8'h00;
         r_data_tx   <= 8'h00;
         r_start     <= 1'b0;
         r_stop      <= 1'b0;
         r_dir       <= 1'b0;
         r_do        <= 1'b0;
      end else begin
         r_do       <= 1'b0;
         r_rsp_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (host.req_valid && r_req_ready) begin
                  r_rnw       <= host.req_rnw;
                  r_dev       <= host.req_dev_sel ? host.req_dev : DEV_ADDR;
                  r_reg       <= host.req_reg;
                  r_wdata     <= host.req_wdata;
                  r_req_ready <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= 8'h00;
                  r_step      <= STEP_DEV_W;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (ctl.ctl_ready) begin
                  r_data_tx <= w_tx_byte;
                  r_start   <= w_start;
                  r_stop    <= w_stop;
                  r_dir     <= w_dir;
                  r_do      <= 1'b1;
                  r_skip    <= 1'b1;
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Controller drops ready one cycle after do, so the first WAIT cycle is blind.
               if (r_skip) begin
                  r_skip <= 1'b0;
               end else if (ctl.ctl_ready) begin
                  if ((r_dir == C_DIR_TX) && ctl.ctl_error) begin
                     r_rsp_err  <= 1'b1;
                     r_rsp_done <= 1'b1;
                     r_state    <= ST_DONE;
                  end else if (is_last_step(r_step)) begin
                     if (r_dir == C_DIR_RX) begin
                        r_rsp_rdata <= ctl.ctl_data_rx;
                     end
                     r_rsp_done <= 1'b1;
                     r_state    <= ST_DONE;
                  end else begin
                     r_step  <= next_step(r_step, r_rnw, C_TWO_BYTE);
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               r_req_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign host.req_ready = r_req_ready;
   assign host.rsp_done  = r_rsp_done;
   assign host.rsp_err   = r_rsp_err;
   assign host.rsp_rdata = r_rsp_rdata;

   assign ctl.ctl_data_tx = r_data_tx;
   assign ctl.ctl_start   = r_start;
   assign ctl.ctl_stop    = r_stop;
   assign ctl.ctl_dir     = r_dir;
   assign ctl.ctl_do      = r_do;

endmodule
`default_nettype wire

// File: tb/tb_iic_reg_access.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_iic_reg_access : scoreboard bench with a 20-cycle controller model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_iic_reg_access;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   iic_req_if h1 ();
   iic_req_if h2 ();
   iic_ctl_if c1 ();
   iic_ctl_if c2 ();

   iic_reg_access #(.REG_ADDR_BYTES(1), .DEV_ADDR(7'h50)) u_dut1 (
      .clk (clk), .rst (rst), .host (h1), .ctl (c1)
   );
   iic_reg_access #(.REG_ADDR_BYTES(2), .DEV_ADDR(7'h50)) u_dut2 (
      .clk (clk), .rst (rst), .host (h2), .ctl (c2)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Controller models: ack every byte, ready returns 20 cycles after do.
   logic m1_ready, m1_err, m1_pend, hold1;
   logic m2_ready, m2_err, m2_pend, hold2;
   int   m1_cnt, m1_byte, inj1;
   int   m2_cnt, m2_byte, inj2;
   logic [7:0] rx1, rx2;

   assign c1.ctl_ready   = m1_ready & ~hold1;
   assign c1.ctl_error   = m1_err;
   assign c1.ctl_data_rx = rx1;
   assign c2.ctl_ready   = m2_ready & ~hold2;
   assign c2.ctl_error   = m2_err;
   assign c2.ctl_data_rx = rx2;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m1_ready <= 1'b1; m1_cnt <= 0; m1_err <= 1'b0; m1_pend <= 1'b0; m1_byte <= 0;
      end else begin
         if (c1.ctl_do) begin
            m1_ready <= 1'b0; m1_cnt <= 20; m1_err <= 1'b0;
            m1_pend  <= (inj1 == m1_byte); m1_byte <= m1_byte + 1;
         end else if (m1_cnt == 1) begin
            m1_cnt <= 0; m1_ready <= 1'b1; m1_err <= m1_pend;
         end else if (m1_cnt > 1) begin
            m1_cnt <= m1_cnt - 1;
         end
         if (h1.rsp_done) m1_byte <= 0;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m2_ready <= 1'b1; m2_cnt <= 0; m2_err <= 1'b0; m2_pend <= 1'b0; m2_byte <= 0;
      end else begin
         if (c2.ctl_do) begin
            m2_ready <= 1'b0; m2_cnt <= 20; m2_err <= 1'b0;
            m2_pend  <= (inj2 == m2_byte); m2_byte <= m2_byte + 1;
         end else if (m2_cnt == 1) begin
            m2_cnt <= 0; m2_ready <= 1'b1; m2_err <= m2_pend;
         end else if (m2_cnt > 1) begin
            m2_cnt <= m2_cnt - 1;
         end
         if (h2.rsp_done) m2_byte <= 0;
      end
   end

   // Scoreboard: commands are {start,stop,dir,data}, responses are {err,rdata}.
   logic [10:0] exp_cmd1[$], exp_cmd2[$];
   logic [8:0]  exp_rsp1[$], exp_rsp2[$];
   int   do_cnt1 = 0, do_cnt2 = 0, acc1 = 0, acc2 = 0, done1 = 0, done2 = 0;
   logic prev_do1 = 1'b0, prev_do2 = 1'b0, done_prev1 = 1'b0, done_prev2 = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (c1.ctl_do) begin
            do_cnt1 <= do_cnt1 + 1;
            check_eq("do_width1", prev_do1, 1'b0);
            if (exp_cmd1.size() == 0) check_eq("unexp_do1", exp_cmd1.size(), 1);
            else check_eq("cmd1", {c1.ctl_start, c1.ctl_stop, c1.ctl_dir, c1.ctl_data_tx}, exp_cmd1.pop_front());
         end
         prev_do1 <= c1.ctl_do;
         if (h1.req_valid && h1.req_ready) acc1 <= acc1 + 1;
         if (done_prev1) check_eq("rdy_after_done1", h1.req_ready, 1'b1);
         if (h1.rsp_done) begin
            done1 <= done1 + 1;
            if (exp_rsp1.size() == 0) check_eq("unexp_done1", exp_rsp1.size(), 1);
            else check_eq("rsp1", {h1.rsp_err, h1.rsp_rdata}, exp_rsp1.pop_front());
         end
         done_prev1 <= h1.rsp_done;

         if (c2.ctl_do) begin
            do_cnt2 <= do_cnt2 + 1;
            check_eq("do_width2", prev_do2, 1'b0);
            if (exp_cmd2.size() == 0) check_eq("unexp_do2", exp_cmd2.size(), 1);
            else check_eq("cmd2", {c2.ctl_start, c2.ctl_stop, c2.ctl_dir, c2.ctl_data_tx}, exp_cmd2.pop_front());
         end
         prev_do2 <= c2.ctl_do;
         if (h2.req_valid && h2.req_ready) acc2 <= acc2 + 1;
         if (done_prev2) check_eq("rdy_after_done2", h2.req_ready, 1'b1);
         if (h2.rsp_done) begin
            done2 <= done2 + 1;
            if (exp_rsp2.size() == 0) check_eq("unexp_done2", exp_rsp2.size(), 1);
            else check_eq("rsp2", {h2.rsp_err, h2.rsp_rdata}, exp_rsp2.pop_front());
         end
         done_prev2 <= h2.rsp_done;
      end
   end

   task automatic push_exp(input int idx, input logic rnw, input logic [6:0] dev,
                           input logic [15:0] rg, input logic [7:0] wd, input int nack);
      logic [10:0] b[$];
      logic [8:0]  rsp;
      logic [7:0]  rx;
      rx = (idx == 1) ? rx1 : rx2;
      b.push_back({3'b100, dev, 1'b0});
      if (idx == 2) b.push_back({3'b000, rg[15:8]});
      b.push_back({3'b000, rg[7:0]});
      if (rnw) begin
         b.push_back({3'b100, dev, 1'b1});
         b.push_back({3'b011, 8'h00});
         rsp = {1'b0, rx};
      end else begin
         b.push_back({3'b010, wd});
         rsp = 9'h000;
      end
      if (nack >= 0 && nack < b.size()) begin
         while (b.size() > nack + 1) void'(b.pop_back());
         rsp = 9'h100;
      end
      foreach (b[i]) begin
         if (idx == 1) exp_cmd1.push_back(b[i]); else exp_cmd2.push_back(b[i]);
      end
      if (idx == 1) exp_rsp1.push_back(rsp); else exp_rsp2.push_back(rsp);
   endtask

   task automatic do_req(input int idx, input logic rnw, input logic sel, input logic [6:0] dev,
                         input logic [15:0] rg, input logic [7:0] wd, input logic hold, input int nack);
      logic ok;
      @(posedge clk); #1;
      if (idx == 1) begin
         inj1 = nack; h1.req_rnw = rnw; h1.req_dev_sel = sel; h1.req_dev = dev;
         h1.req_reg = rg; h1.req_wdata = wd; h1.req_valid = 1'b1;
      end else begin
         inj2 = nack; h2.req_rnw = rnw; h2.req_dev_sel = sel; h2.req_dev = dev;
         h2.req_reg = rg; h2.req_wdata = wd; h2.req_valid = 1'b1;
      end
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if ((idx == 1) ? (h1.req_valid && h1.req_ready) : (h2.req_valid && h2.req_ready)) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("accept", ok, 1'b1);
      if (ok) push_exp(idx, rnw, sel ? dev : 7'h50, rg, wd, nack);
      @(posedge clk); #1;
      if (!hold) begin
         if (idx == 1) h1.req_valid = 1'b0; else h2.req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input int idx);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ((idx == 1) ? (exp_rsp1.size() == 0 && h1.req_ready) : (exp_rsp2.size() == 0 && h2.req_ready)) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("idle_timeout", ok, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_1"}, {h1.req_ready, c1.ctl_do, h1.rsp_done, h1.rsp_err, h1.rsp_rdata,
                             c1.ctl_data_tx, c1.ctl_start, c1.ctl_stop, c1.ctl_dir}, 32'h400000);
      check_eq({tag, "_2"}, {h2.req_ready, c2.ctl_do, h2.rsp_done, h2.rsp_err, h2.rsp_rdata,
                             c2.ctl_data_tx, c2.ctl_start, c2.ctl_stop, c2.ctl_dir}, 32'h400000);
   endtask

   initial begin
      int base_do, base_acc, base_done;
      logic ok;
      h1.req_valid = 1'b0; h1.req_rnw = 1'b0; h1.req_dev_sel = 1'b0; h1.req_dev = 7'h0;
      h1.req_reg = 16'h0; h1.req_wdata = 8'h0;
      h2.req_valid = 1'b0; h2.req_rnw = 1'b0; h2.req_dev_sel = 1'b0; h2.req_dev = 7'h0;
      h2.req_reg = 16'h0; h2.req_wdata = 8'h0;
      hold1 = 1'b0; hold2 = 1'b0; inj1 = -1; inj2 = -1; rx1 = 8'h5A; rx2 = 8'h3C;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst = 1'b0;

      // 1: write, one register byte
      do_req(1, 1'b0, 1'b0, 7'h00, 16'h0012, 8'hA5, 1'b0, -1);
      wait_idle(1);

      // 2: read, two register bytes
      do_req(2, 1'b1, 1'b0, 7'h00, 16'h1234, 8'h00, 1'b0, -1);
      wait_idle(2);

      // 3: NACK on REG_LO (byte index 2 with two address bytes)
      do_req(2, 1'b0, 1'b0, 7'h00, 16'h5678, 8'hEE, 1'b0, 2);
      wait_idle(2);
      repeat (30) @(posedge clk);

      // 4: req_valid held high across a transaction
      base_acc = acc2; base_done = done2;
      do_req(2, 1'b0, 1'b1, 7'h2B, 16'h0102, 8'h11, 1'b1, -1);
      do_req(2, 1'b1, 1'b0, 7'h00, 16'h0304, 8'h00, 1'b0, -1);
      wait_idle(2);
      repeat (5) @(posedge clk);
      check_eq("accept_count", acc2 - base_acc, 2);
      check_eq("done_count", done2 - base_done, 2);

      // 5: ctl_ready low for 50 cycles before the first step
      hold2 = 1'b1;
      base_do = do_cnt2;
      do_req(2, 1'b0, 1'b0, 7'h00, 16'h00C3, 8'h99, 1'b0, -1);
      repeat (50) @(posedge clk);
      #1;
      check_eq("do_withheld", do_cnt2 - base_do, 0);
      hold2 = 1'b0;
      wait_idle(2);

      // 6: reset during RD_DATA
      base_do = do_cnt2;
      do_req(2, 1'b1, 1'b0, 7'h00, 16'h0A0B, 8'h00, 1'b0, -1);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (do_cnt2 - base_do >= 5) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("rd_data_reached", ok, 1'b1);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_outputs("mid_reset");
      exp_cmd2.delete();
      exp_rsp2.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      do_req(2, 1'b0, 1'b0, 7'h00, 16'h00AB, 8'h77, 1'b0, -1);
      wait_idle(2);
      repeat (5) @(posedge clk);
      check_eq("leftover_cmd", exp_cmd1.size() + exp_cmd2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
